// File: rtl/segment_reader.sv
// Seven-segment receive monitor: rebuilds the displayed hex word from the multiplexed anode/segment/sign lines.
// Define SEG_READER_BLANK_EN to accept the all-off pattern as a blank digit (nibble 0, flagged in blank_mask).
module segment_reader #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    input  logic                    sign_in,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    sign,
    output logic                    frame_valid,
    output logic                    err_illegal,
    output logic                    timeout,
    output logic [NUM_DIGITS-1:0]   blank_mask
);

    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_HELD  = 2'd2;

    // Returns {legal, nibble}; the blank pattern is only legal in the blank-enabled build.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0001100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
`ifdef SEG_READER_BLANK_EN
            7'b1111111: return 5'h10;
`endif
            default:    return 5'h00;
        endcase
    endfunction

    logic [1:0]              r_state;
    logic [CW-1:0]           r_cnt;
    logic [SW-1:0]           r_prev;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_mask;
    logic                    r_shadow_sign;
    logic [TW-1:0]           r_tcount;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic                    r_sign;
    logic                    r_frame_valid;
    logic                    r_err_illegal;
    logic                    r_timeout;

    logic [SW-1:0]           w_sample;
    logic                    w_an_legal;
    logic                    w_changed;
    logic [IW-1:0]           w_idx;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [4:0]              w_dec;
    logic [1:0]              w_state_next;
    logic [CW-1:0]           w_cnt_next;
    logic                    w_capture;
    logic                    w_cap_legal;
    logic                    w_cap_illegal;
    logic [NUM_DIGITS-1:0]   w_mask_next;
    logic [4*NUM_DIGITS-1:0] w_shadow_next;
    logic                    w_sign_next;
    logic                    w_complete;

    assign w_sample   = {an, seg, sign_in};
    assign w_an_legal = $onehot(~an);
    assign w_changed  = (w_sample != r_prev);
    assign w_sel      = ~an;
    assign w_dec      = decode(seg);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) w_idx = IW'(i);
        end
    end

    // The incoming sample is compared against last cycle's, so a digit held from
    // cycle 0 reaches the capture count on edge STABLE_CYCLES-1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_an_legal) begin
                    w_state_next = S_TRACK;
                    w_cnt_next   = CW'(1);
                end
            end
            S_TRACK: begin
                if (!w_an_legal) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (w_changed) begin
                    w_cnt_next = CW'(1);
                end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HELD;
                    w_cnt_next   = CW'(STABLE_CYCLES);
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_HELD: begin
                if (!w_an_legal) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (w_changed) begin
                    w_state_next = S_TRACK;
                    w_cnt_next   = CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_cap_legal   = w_capture & w_dec[4];
    assign w_cap_illegal = w_capture & ~w_dec[4];

    always_comb begin
        w_shadow_next = r_shadow;
        w_mask_next   = r_shadow_mask;
        w_sign_next   = r_shadow_sign;
        if (w_cap_legal) begin
            w_shadow_next[{w_idx, 2'b00} +: 4] = w_dec[3:0];
            w_mask_next = r_shadow_mask | w_sel;
            if (w_idx == IW'(NUM_DIGITS - 1)) w_sign_next = sign_in;
        end else if (w_cap_illegal) begin
            w_mask_next = r_shadow_mask & ~w_sel;
        end
    end

    assign w_complete = w_cap_legal & (&w_mask_next);

    // Completion takes priority over the timeout; a capture landing on a timeout edge is dropped with the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_prev        <= '0;
            r_shadow      <= '0;
            r_shadow_mask <= '0;
            r_shadow_sign <= 1'b0;
            r_tcount      <= '0;
            r_value       <= '0;
            r_sign        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_err_illegal <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_prev        <= w_sample;
            r_shadow      <= w_shadow_next;
            r_shadow_sign <= w_sign_next;
            r_frame_valid <= w_complete;
            r_err_illegal <= w_cap_illegal;
            r_timeout     <= 1'b0;
            if (w_complete) begin
                r_value       <= w_shadow_next;
                r_sign        <= w_sign_next;
                r_shadow_mask <= '0;
                r_tcount      <= '0;
            end else if (r_tcount == TW'(TIMEOUT_CYCLES - 1)) begin
                r_timeout     <= 1'b1;
                r_shadow_mask <= '0;
                r_tcount      <= '0;
            end else begin
                r_shadow_mask <= w_mask_next;
                r_tcount      <= r_tcount + TW'(1);
            end
        end
    end

`ifdef SEG_READER_BLANK_EN
    logic [NUM_DIGITS-1:0] r_shadow_blank;
    logic [NUM_DIGITS-1:0] r_blank_mask;
    logic [NUM_DIGITS-1:0] w_blank_next;

    always_comb begin
        w_blank_next = r_shadow_blank;
        if (w_cap_legal) w_blank_next[w_idx] = (seg == 7'b1111111);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_blank <= '0;
            r_blank_mask   <= '0;
        end else begin
            r_shadow_blank <= w_blank_next;
            if (w_complete) r_blank_mask <= w_blank_next;
        end
    end

    assign blank_mask = r_blank_mask;
`else
    assign blank_mask = '0;
`endif

    assign value       = r_value;
    assign sign        = r_sign;
    assign frame_valid = r_frame_valid;
    assign err_illegal = r_err_illegal;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_segment_reader.sv
// Self-checking bench for segment_reader: directed scenarios plus randomized display traffic
// checked every cycle against a run-length based reference model.
module tb_segment_reader;

    localparam int ND      = 4;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1024;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic          clk = 1'b0;
    logic          reset;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          signIn;
    logic [15:0]   value;
    logic          sign;
    logic          frame_valid;
    logic          err_illegal;
    logic          timeout;
    logic [ND-1:0] blank_mask;

    int total = 0;
    int bad   = 0;
    int fvSeen, errSeen, toSeen;

    // Reference model state
    logic [11:0] mPrev;
    bit          mPrevValid;
    int          mRun;
    logic [3:0]  mNib [ND];
    bit   [3:0]  mMask;
    bit   [3:0]  mBlankSh;
    bit          mSignSh;
    int          mTcount;
    logic [15:0] expValue;
    bit          expSign, expFv, expErr, expTo;
    logic [3:0]  expBlank;

    segment_reader #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .sign_in(signIn),
        .value(value), .sign(sign), .frame_valid(frame_valid),
        .err_illegal(err_illegal), .timeout(timeout), .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A digit is captured on the sample that completes a run of STABLE identical legal samples.
    task automatic modelEdge();
        int zeros, idx, nib;
        bit legalPat, isBlank, complete;
        logic [11:0] smp;
        expFv = 0; expErr = 0; expTo = 0;
        if (reset) begin
            mPrevValid = 0; mRun = 0; mMask = 0; mBlankSh = 0; mSignSh = 0; mTcount = 0;
            for (int k = 0; k < ND; k++) mNib[k] = 4'h0;
            expValue = 16'h0; expSign = 0; expBlank = 4'h0;
            return;
        end
        zeros = 0; idx = 0;
        for (int i = 0; i < ND; i++) if (an[i] == 1'b0) begin zeros++; idx = i; end
        smp = {an, seg, signIn};
        if (zeros != 1) mRun = 0;
        else if (mPrevValid && smp == mPrev) begin if (mRun <= STABLE) mRun++; end
        else mRun = 1;
        mPrev = smp; mPrevValid = 1;
        complete = 0;
        if (zeros == 1 && mRun == STABLE) begin
            legalPat = 0; nib = 0; isBlank = 0;
            for (int k = 0; k < 16; k++) if (seg == SEG_TABLE[k]) begin legalPat = 1; nib = k; end
`ifdef SEG_READER_BLANK_EN
            if (seg == 7'b1111111) begin legalPat = 1; nib = 0; isBlank = 1; end
`endif
            if (legalPat) begin
                mNib[idx] = 4'(nib);
                mMask[idx] = 1;
                mBlankSh[idx] = isBlank;
                if (idx == ND - 1) mSignSh = signIn;
                if (mMask == 4'hF) complete = 1;
            end else begin
                expErr = 1;
                mMask[idx] = 0;
            end
        end
        if (complete) begin
            expValue = {mNib[3], mNib[2], mNib[1], mNib[0]};
            expSign  = mSignSh;
            expBlank = mBlankSh;
            expFv    = 1;
            mMask    = 0;
            mTcount  = 0;
        end else if (mTcount == TIMEOUT - 1) begin
            expTo   = 1;
            mMask   = 0;
            mTcount = 0;
        end else begin
            mTcount++;
        end
    endtask

    task automatic tickClock();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("value", 32'(value), 32'(expValue));
        checkOutput("sign", 32'(sign), 32'(expSign));
        checkOutput("frame_valid", 32'(frame_valid), 32'(expFv));
        checkOutput("err_illegal", 32'(err_illegal), 32'(expErr));
        checkOutput("timeout", 32'(timeout), 32'(expTo));
        checkOutput("blank_mask", 32'(blank_mask), 32'(expBlank));
        if (frame_valid) fvSeen++;
        if (err_illegal) errSeen++;
        if (timeout) toSeen++;
    endtask

    task automatic applyStimulus(input logic [3:0] anV, input logic [6:0] segV, input logic sgn, input int cycles);
        an = anV; seg = segV; signIn = sgn;
        repeat (cycles) tickClock();
    endtask

    task automatic clearSeen();
        fvSeen = 0; errSeen = 0; toSeen = 0;
    endtask

    task automatic sendFrame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                             input logic [3:0] d3, input logic sgn);
        applyStimulus(4'b1110, SEG_TABLE[d0], 1'b0, STABLE);
        applyStimulus(4'b1101, SEG_TABLE[d1], 1'b0, STABLE);
        applyStimulus(4'b1011, SEG_TABLE[d2], 1'b0, STABLE);
        applyStimulus(4'b0111, SEG_TABLE[d3], sgn, STABLE);
        applyStimulus(4'b1111, 7'b1111111, 1'b0, 3);
    endtask

    initial begin
        logic [3:0] anR;
        logic [6:0] segR;
        int pick;
        reset = 1'b1; an = 4'b1111; seg = 7'b1111111; signIn = 1'b0;
        clearSeen();
        repeat (3) tickClock();
        checkOutput("reset_value", 32'(value), 32'h0);
        checkOutput("reset_fv", 32'(frame_valid), 32'h0);
        reset = 1'b0;

        $display("[TB] basic frame");
        clearSeen();
        sendFrame(4'h3, 4'h5, 4'hA, 4'hF, 1'b1);
        checkOutput("frame1_count", 32'(fvSeen), 32'd1);
        checkOutput("frame1_value", 32'(value), 32'hFA53);
        checkOutput("frame1_sign", 32'(sign), 32'd1);

        $display("[TB] short dwell then full sequence");
        clearSeen();
        applyStimulus(4'b1110, SEG_TABLE[1], 1'b0, STABLE - 1);
        sendFrame(4'h2, 4'h4, 4'h7, 4'h9, 1'b0);
        checkOutput("short_count", 32'(fvSeen), 32'd1);
        checkOutput("short_value", 32'(value), 32'h9742);

        $display("[TB] illegal pattern then recapture");
        clearSeen();
        applyStimulus(4'b1110, SEG_TABLE[0], 1'b0, STABLE);
        applyStimulus(4'b1101, SEG_TABLE[8], 1'b0, STABLE);
        applyStimulus(4'b1011, 7'b1111110, 1'b0, STABLE);
        applyStimulus(4'b0111, SEG_TABLE[11], 1'b1, STABLE);
        checkOutput("illegal_err", 32'(errSeen), 32'd1);
        checkOutput("illegal_nofv", 32'(fvSeen), 32'd0);
        applyStimulus(4'b1011, SEG_TABLE[12], 1'b0, STABLE + 1);
        checkOutput("recap_count", 32'(fvSeen), 32'd1);
        checkOutput("recap_value", 32'(value), 32'hBC80);

        $display("[TB] illegal anodes");
        clearSeen();
        applyStimulus(4'b1100, SEG_TABLE[3], 1'b0, 10);
        applyStimulus(4'b1111, SEG_TABLE[3], 1'b0, 10);
        checkOutput("anode_err", 32'(errSeen), 32'd0);
        checkOutput("anode_fv", 32'(fvSeen), 32'd0);

        $display("[TB] timeout of a partial frame");
        clearSeen();
        applyStimulus(4'b1110, SEG_TABLE[1], 1'b0, STABLE);
        applyStimulus(4'b1101, SEG_TABLE[2], 1'b0, STABLE);
        applyStimulus(4'b1011, SEG_TABLE[3], 1'b0, STABLE);
        applyStimulus(4'b1111, 7'b1111111, 1'b0, TIMEOUT);
        checkOutput("timeout_count", 32'(toSeen), 32'd1);
        checkOutput("timeout_value", 32'(value), 32'hBC80);
        checkOutput("timeout_nofv", 32'(fvSeen), 32'd0);
        sendFrame(4'h4, 4'h5, 4'h6, 4'h7, 1'b0);
        checkOutput("after_to_count", 32'(fvSeen), 32'd1);
        checkOutput("after_to_value", 32'(value), 32'h7654);

        $display("[TB] reset mid-frame");
        clearSeen();
        applyStimulus(4'b1110, SEG_TABLE[9], 1'b0, STABLE);
        applyStimulus(4'b1101, SEG_TABLE[9], 1'b0, STABLE);
        reset = 1'b1;
        applyStimulus(4'b1111, 7'b1111111, 1'b0, 3);
        checkOutput("rst_value", 32'(value), 32'h0);
        checkOutput("rst_sign", 32'(sign), 32'h0);
        reset = 1'b0;
        sendFrame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        checkOutput("rst_frame_count", 32'(fvSeen), 32'd1);
        checkOutput("rst_frame_value", 32'(value), 32'h4321);

        $display("[TB] blank digit");
        clearSeen();
        applyStimulus(4'b1110, SEG_TABLE[5], 1'b0, STABLE);
        applyStimulus(4'b1101, SEG_TABLE[6], 1'b0, STABLE);
        applyStimulus(4'b1011, SEG_TABLE[7], 1'b0, STABLE);
        applyStimulus(4'b0111, 7'b1111111, 1'b0, STABLE + 1);
`ifdef SEG_READER_BLANK_EN
        checkOutput("blank_fv", 32'(fvSeen), 32'd1);
        checkOutput("blank_value", 32'(value), 32'h0765);
        checkOutput("blank_mask", 32'(blank_mask), 32'h8);
`else
        checkOutput("blank_err", 32'(errSeen), 32'd1);
        checkOutput("blank_nofv", 32'(fvSeen), 32'd0);
`endif

        $display("[TB] randomized traffic");
        for (int ep = 0; ep < 500; ep++) begin
            pick = $urandom_range(0, 9);
            if (pick < 8) anR = ~(4'b0001 << $urandom_range(0, 3));
            else anR = 4'($urandom_range(0, 15));
            pick = $urandom_range(0, 15);
            if (pick < 12) segR = SEG_TABLE[$urandom_range(0, 15)];
            else if (pick < 14) segR = 7'b1111111;
            else segR = 7'($urandom_range(0, 127));
            reset = ($urandom_range(0, 60) == 0);
            applyStimulus(anR, segR, 1'($urandom_range(0, 1)), $urandom_range(1, 7));
            reset = 1'b0;
        end
        applyStimulus(4'b1111, 7'b1111111, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
